// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding,
// and fills the IF/ID register with stall, redirect and bubble handling.
module fetch_unit #(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h00000000,
  parameter logic [N-1:0] NOP      = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  input  logic         stall,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         if_id_valid,
  output logic [N-1:0] if_id_inst,
  output logic [N-1:0] if_id_pc,
  output logic [N-1:0] if_id_pc4
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t       r_state, w_state;
  logic [N-1:0] r_pc, w_pc;
  logic         r_drop, w_drop;
  logic [N-1:0] r_hold, w_hold;
  logic         r_valid, w_valid;
  logic [N-1:0] r_inst, w_inst;
  logic [N-1:0] r_ipc, w_ipc;
  logic [N-1:0] r_ipc4, w_ipc4;
  logic         w_deliver;
  logic [N-1:0] w_deliver_inst;
  logic [N-1:0] w_pc4;

  assign w_pc4 = r_pc + N'(4);

  // Request is suppressed while reset is held so the memory sees no pulse.
  assign imem_req    = rst && (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign if_id_valid = r_valid;
  assign if_id_inst  = r_inst;
  assign if_id_pc    = r_ipc;
  assign if_id_pc4   = r_ipc4;

  always_comb begin
    w_state        = r_state;
    w_pc           = r_pc;
    w_drop         = r_drop;
    w_hold         = r_hold;
    w_deliver      = 1'b0;
    w_deliver_inst = imem_rdata;
    if (redirect) begin
      w_pc = {redirect_pc[N-1:2], 2'b00};
      case (r_state)
        FETCH:   begin w_drop = 1'b1; w_state = WAIT; end
        WAIT:    if (imem_rvalid) begin w_drop = 1'b0; w_state = FETCH; end
                 else w_drop = 1'b1;
        default: w_state = FETCH;
      endcase
    end else begin
      case (r_state)
        FETCH: w_state = WAIT;
        WAIT: if (imem_rvalid) begin
          if (r_drop) begin
            w_drop  = 1'b0;
            w_state = FETCH;
          end else if (!stall) begin
            w_deliver = 1'b1;
            w_pc      = w_pc4;
            w_state   = FETCH;
          end else begin
            w_hold  = imem_rdata;
            w_state = HOLD;
          end
        end
        HOLD: if (!stall) begin
          w_deliver      = 1'b1;
          w_deliver_inst = r_hold;
          w_pc           = w_pc4;
          w_state        = FETCH;
        end
        default: w_state = FETCH;
      endcase
    end
  end

  // IF/ID priority: flush on redirect, then hold on stall, then load, else bubble.
  always_comb begin
    w_valid = 1'b0;
    w_inst  = NOP;
    w_ipc   = r_ipc;
    w_ipc4  = r_ipc4;
    if (!redirect) begin
      if (stall) begin
        w_valid = r_valid;
        w_inst  = r_inst;
      end else if (w_deliver) begin
        w_valid = 1'b1;
        w_inst  = w_deliver_inst;
        w_ipc   = r_pc;
        w_ipc4  = w_pc4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
      r_hold  <= '0;
      r_valid <= 1'b0;
      r_inst  <= NOP;
      r_ipc   <= '0;
      r_ipc4  <= '0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_drop  <= w_drop;
      r_hold  <= w_hold;
      r_valid <= w_valid;
      r_inst  <= w_inst;
      r_ipc   <= w_ipc;
      r_ipc4  <= w_ipc4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-computed IF/ID and imem request values.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] inst,
                          input logic [31:0] pc, input logic [31:0] pc4);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, "_inst"},  if_id_inst, inst);
    chk({tag, "_pc"},    if_id_pc,   pc);
    chk({tag, "_pc4"},   if_id_pc4,  pc4);
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    rst = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk_ifid("rst", 1'b0, NOP, 32'h0, 32'h0);
    chk_req("rst", 1'b0, 32'h0);

    // basic 1-cycle-latency fetch
    rst = 1'b1; #1;
    chk_req("f0", 1'b1, 32'h0);
    tick();
    chk_req("w0", 1'b0, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h00500093; tick(); imem_rvalid = 1'b0;
    chk_ifid("i0", 1'b1, 32'h00500093, 32'h0, 32'h4);
    chk_req("f1", 1'b1, 32'h4);
    tick();
    chk_ifid("bub", 1'b0, NOP, 32'h0, 32'h4);
    imem_rvalid = 1'b1; imem_rdata = 32'h00A00113; tick(); imem_rvalid = 1'b0;
    chk_ifid("i1", 1'b1, 32'h00A00113, 32'h4, 32'h8);
    chk_req("f2", 1'b1, 32'h8);

    // stall: request still issues, response parks in hold buffer
    stall = 1'b1; tick();
    chk_ifid("st0", 1'b1, 32'h00A00113, 32'h4, 32'h8);
    chk_req("st0", 1'b0, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h11111111; tick(); imem_rvalid = 1'b0;
    chk_ifid("st1", 1'b1, 32'h00A00113, 32'h4, 32'h8);
    tick();
    chk_req("st2", 1'b0, 32'h0);
    chk_ifid("st2", 1'b1, 32'h00A00113, 32'h4, 32'h8);
    stall = 1'b0; tick();
    chk_ifid("hld", 1'b1, 32'h11111111, 32'h8, 32'hC);
    chk_req("hld", 1'b1, 32'hC);

    // redirect during WAIT, late response discarded
    tick();
    redirect = 1'b1; redirect_pc = 32'h40; tick(); redirect = 1'b0;
    chk_ifid("rw0", 1'b0, NOP, 32'h8, 32'hC);
    chk_req("rw0", 1'b0, 32'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF; tick(); imem_rvalid = 1'b0;
    chk_ifid("rw1", 1'b0, NOP, 32'h8, 32'hC);
    chk_req("rw1", 1'b1, 32'h40);

    // redirect + stall in HOLD
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h33333333; tick(); imem_rvalid = 1'b0;
    chk_ifid("i40", 1'b1, 32'h33333333, 32'h40, 32'h44);
    stall = 1'b1; tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h22222222; tick(); imem_rvalid = 1'b0;
    chk_ifid("rh0", 1'b1, 32'h33333333, 32'h40, 32'h44);
    redirect = 1'b1; redirect_pc = 32'h80; tick(); redirect = 1'b0; stall = 1'b0;
    chk_ifid("rh1", 1'b0, NOP, 32'h40, 32'h44);
    chk_req("rh1", 1'b1, 32'h80);
    tick();
    chk_ifid("rh2", 1'b0, NOP, 32'h40, 32'h44);
    chk_req("rh2", 1'b0, 32'h0);

    // redirect with rvalid same cycle, misaligned target
    redirect = 1'b1; redirect_pc = 32'h43; imem_rvalid = 1'b1; imem_rdata = 32'h44444444;
    tick(); redirect = 1'b0; imem_rvalid = 1'b0;
    chk_req("ra", 1'b1, 32'h40);
    chk_ifid("ra", 1'b0, NOP, 32'h40, 32'h44);

    // redirect in FETCH orphans that request; then PC wrap
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC; tick(); redirect = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h55555555; tick(); imem_rvalid = 1'b0;
    chk_ifid("orph", 1'b0, NOP, 32'h40, 32'h44);
    chk_req("orph", 1'b1, 32'hFFFFFFFC);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h66666666; tick(); imem_rvalid = 1'b0;
    chk_ifid("wrap", 1'b1, 32'h66666666, 32'hFFFFFFFC, 32'h0);
    chk_req("wrap", 1'b1, 32'h0);

    // reset in WAIT with a response pending
    tick();
    rst = 1'b0; tick();
    chk_ifid("rst2", 1'b0, NOP, 32'h0, 32'h0);
    chk_req("rst2", 1'b0, 32'h0);
    rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h77777777; #1;
    chk_req("rst3", 1'b1, 32'h0);
    tick(); imem_rvalid = 1'b0;
    chk_ifid("late", 1'b0, NOP, 32'h0, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h88888888; tick(); imem_rvalid = 1'b0;
    chk_ifid("post", 1'b1, 32'h88888888, 32'h0, 32'h4);
    chk_req("post", 1'b1, 32'h4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
